// File: rtl/p4_router_queue_dequeue_sched_if.sv
// Handshake bundle between the dequeue scheduler and the queue-state store
// (head-pointer AR/R), the packet-buffer read path and the occupancy tracker.
interface p4_router_queue_dequeue_sched_if #(
   parameter int QL        = 5,
   parameter int PL        = 10,
   parameter int WL        = 6,
   parameter int OCC_WIDTH = 24
);
   logic                 hp_arvalid;
   logic                 hp_arready;
   logic [QL-1:0]        hp_araddr;
   logic                 hp_rvalid;
   logic                 hp_rready;
   logic [PL-1:0]        hp_rdata_page;
   logic [WL-1:0]        hp_rdata_word;
   logic                 rd_req_valid;
   logic                 rd_req_ready;
   logic [PL-1:0]        rd_req_page;
   logic [WL-1:0]        rd_req_word;
   logic [QL-1:0]        rd_req_queue;
   logic                 rd_req_last;
   logic                 deq_occ_tvalid;
   logic [OCC_WIDTH-1:0] deq_occ_tdata;
   logic [QL-1:0]        deq_occ_tuser;

   modport master (
      output hp_arvalid, hp_araddr, hp_rready,
      input  hp_arready, hp_rvalid, hp_rdata_page, hp_rdata_word,
      output rd_req_valid, rd_req_page, rd_req_word, rd_req_queue, rd_req_last,
      input  rd_req_ready,
      output deq_occ_tvalid, deq_occ_tdata, deq_occ_tuser
   );

   modport slave (
      input  hp_arvalid, hp_araddr, hp_rready,
      output hp_arready, hp_rvalid, hp_rdata_page, hp_rdata_word,
      input  rd_req_valid, rd_req_page, rd_req_word, rd_req_queue, rd_req_last,
      output rd_req_ready,
      input  deq_occ_tvalid, deq_occ_tdata, deq_occ_tuser
   );
endinterface

// File: rtl/p4_router_queue_dequeue_sched.sv
// Dequeue scheduler: round-robin grant of an eligible queue, per-word head-pointer
// lookup and buffer read request, then one byte-count debit per grant.
module p4_router_queue_dequeue_sched #(
   parameter int  NUM_EGR_PORTS   = 4,
   parameter int  QUEUES_PER_PORT = 8,
   parameter int  NUM_PAGES       = 1024,
   parameter int  WORDS_PER_PAGE  = 64,
   parameter int  BYTES_PER_WORD  = 64,
   parameter int  BURST_WORDS     = 32,
   parameter int  OCC_WIDTH       = 24,
   localparam int NQ = NUM_EGR_PORTS * QUEUES_PER_PORT,
   localparam int QL = $clog2(NQ),
   localparam int PL = $clog2(NUM_PAGES),
   localparam int WL = $clog2(WORDS_PER_PAGE)
) (
   input  logic                     clk,
   input  logic                     aresetn,
   input  logic [NQ-1:0]            queue_empty,
   input  logic [NUM_EGR_PORTS-1:0] egr_port_ready,
   output logic                     busy,
   p4_router_queue_dequeue_sched_if.master bus
);
   localparam int CW = $clog2(BURST_WORDS + 1);

   if (BURST_WORDS < 1) begin : g_chk_burst
      $error("BURST_WORDS must be at least 1");
   end
   if (longint'(BURST_WORDS) * BYTES_PER_WORD >= (64'd1 << OCC_WIDTH)) begin : g_chk_occ
      $error("OCC_WIDTH cannot hold BURST_WORDS*BYTES_PER_WORD");
   end

   typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_REQ, S_UPD} state_t;

   state_t               r_state;
   logic [QL-1:0]        r_q;
   logic [QL-1:0]        r_rr_ptr;
   logic [CW-1:0]        r_cnt;
   logic                 r_arvalid;
   logic                 r_rready;
   logic                 r_rd_valid;
   logic                 r_rd_last;
   logic [PL-1:0]        r_page;
   logic [WL-1:0]        r_word;
   logic                 r_occ_valid;
   logic [OCC_WIDTH-1:0] r_occ_data;

   logic [NQ-1:0]        w_eligible;
   logic                 w_grant_found;
   logic [QL-1:0]        w_grant_q;
   logic [QL-1:0]        w_rr_next;
   logic [CW-1:0]        w_cnt_inc;

   for (genvar g = 0; g < NQ; g++) begin : g_elig
      assign w_eligible[g] = !queue_empty[g] && egr_port_ready[g / QUEUES_PER_PORT];
   end

   // First eligible queue scanning upward from the round-robin pointer, with wrap.
   always_comb begin
      logic [QL-1:0] v_idx;
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w_grant_found = 1'b0;
      w_grant_q     = '0;
      for (int i = 0; i < NQ; i++) begin
         v_idx = QL'((int'(r_rr_ptr) + i) % NQ);
         if (!w_grant_found && w_eligible[v_idx]) begin
            w_grant_found = 1'b1;
            w_grant_q     = v_idx;
         end
      end
   end

   assign w_rr_next = (w_grant_q == QL'(NQ - 1)) ? '0 : w_grant_q + 1'b1;
   assign w_cnt_inc = r_cnt + 1'b1;

   // NOTE: state is a handful of flops, so every register takes the async reset; sequential logic uses <= only.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_state     <= S_IDLE;
         r_q         <= '0;
         r_rr_ptr    <= '0;
         r_cnt       <= '0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_last   <= 1'b0;
         r_page      <= '0;
         r_word      <= '0;
         r_occ_valid <= 1'b0;
         r_occ_data  <= '0;
      end else begin
         r_occ_valid <= 1'b0;
         unique case (r_state)
            S_IDLE: if (w_grant_found) begin
               r_q       <= w_grant_q;
               r_rr_ptr  <= w_rr_next;
               r_arvalid <= 1'b1;
               r_state   <= S_AR;
            end
            S_AR: if (bus.hp_arready) begin
               r_arvalid <= 1'b0;
               r_rready  <= 1'b1;
               r_state   <= S_R;
            end
            // The store has already cleared queue_empty for the word just looked up.
            S_R: if (bus.hp_rvalid) begin
               r_rready   <= 1'b0;
               r_page     <= bus.hp_rdata_page;
               r_word     <= bus.hp_rdata_word;
               r_cnt      <= w_cnt_inc;
               r_rd_last  <= (w_cnt_inc == CW'(BURST_WORDS)) || queue_empty[r_q];
               r_rd_valid <= 1'b1;
               r_state    <= S_REQ;
            end
            S_REQ: if (bus.rd_req_ready) begin
               r_rd_valid <= 1'b0;
               r_rd_last  <= 1'b0;
               if (r_rd_last) begin
                  r_occ_valid <= 1'b1;
                  r_occ_data  <= OCC_WIDTH'(r_cnt) * OCC_WIDTH'(BYTES_PER_WORD);
                  r_state     <= S_UPD;
               end else begin
                  r_arvalid <= 1'b1;
                  r_state   <= S_AR;
               end
            end
            S_UPD: begin
               r_cnt   <= '0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy               = (r_state != S_IDLE);
   assign bus.hp_arvalid     = r_arvalid;
   assign bus.hp_araddr      = r_arvalid ? r_q : '0;
   assign bus.hp_rready      = r_rready;
   assign bus.rd_req_valid   = r_rd_valid;
   assign bus.rd_req_page    = r_page;
   assign bus.rd_req_word    = r_word;
   assign bus.rd_req_queue   = r_rd_valid ? r_q : '0;
   assign bus.rd_req_last    = r_rd_last;
   assign bus.deq_occ_tvalid = r_occ_valid;
   assign bus.deq_occ_tdata  = r_occ_data;
   assign bus.deq_occ_tuser  = r_occ_valid ? r_q : '0;
endmodule

// File: tb/tb_p4_router_queue_dequeue_sched.sv
// Bench for the dequeue scheduler: a queue-store/read-path responder plus a
// grant-level reference model that predicts every lookup, read request and debit.
module tb_p4_router_queue_dequeue_sched;
   localparam int NEP   = 4;
   localparam int QPP   = 8;
   localparam int NQ    = NEP * QPP;
   localparam int QL    = 5;
   localparam int PL    = 10;
   localparam int WL    = 6;
   localparam int BURST = 32;
   localparam int BPW   = 64;
   localparam int OCC_W = 24;

   typedef struct {
      logic [PL-1:0] page;
      logic [WL-1:0] word;
      int            q;
      logic          last;
   } rd_t;

   typedef struct {
      int data;
      int user;
   } occ_t;

   logic           clk = 1'b0;
   logic           aresetn;
   logic [NQ-1:0]  queue_empty;
   logic [NEP-1:0] egr_port_ready;
   logic           busy;

   p4_router_queue_dequeue_sched_if #(.QL(QL), .PL(PL), .WL(WL), .OCC_WIDTH(OCC_W)) bus ();

   p4_router_queue_dequeue_sched dut (
      .clk            (clk),
      .aresetn        (aresetn),
      .queue_empty    (queue_empty),
      .egr_port_ready (egr_port_ready),
      .busy           (busy),
      .bus            (bus.master)
   );

   always #5 clk = ~clk;

   logic [PL+WL-1:0] store [NQ][$];
   int   exp_ar[$];
   rd_t  exp_rd[$];
   occ_t exp_occ[$];
   int   obs_grants[$];
   int   obs_occ[$];
   int   n_cmp = 0;
   int   n_mis = 0;
   int   m_rr  = 0;
   bit   rand_ready = 1'b0;
   bit   hold_rq    = 1'b0;
   bit   slow_r     = 1'b0;

   function automatic string q2str(input int q[$]);
      string s = "{";
      foreach (q[i]) s = {s, $sformatf("%0d%s", q[i], (i == q.size() - 1) ? "" : ",")};
      return {s, "}"};
   endfunction

   function automatic void refresh_empty();
      for (int i = 0; i < NQ; i++) queue_empty[i] = (store[i].size() == 0);
   endfunction

   function automatic void load_queue(input int q, input int n);
      for (int k = 0; k < n; k++) store[q].push_back((PL + WL)'($urandom));
      refresh_empty();
   endfunction

   function automatic void clear_store();
      for (int i = 0; i < NQ; i++) store[i].delete();
      refresh_empty();
   endfunction

   function automatic void clear_expect();
      exp_ar.delete();
      exp_rd.delete();
      exp_occ.delete();
      obs_grants.delete();
      obs_occ.delete();
   endfunction

   // Grant-level model: round-robin over eligible queues, bursts of min(words, BURST).
   function automatic void build_expected();
      int left[NQ];
      int used[NQ];
      for (int i = 0; i < NQ; i++) begin
         left[i] = store[i].size();
         used[i] = 0;
      end
      for (int guard = 0; guard < NQ * 64; guard++) begin
         int g = -1;
         int n;
         for (int i = 0; i < NQ; i++) begin
            int c = (m_rr + i) % NQ;
            if (g < 0 && left[c] > 0 && egr_port_ready[c / QPP]) g = c;
         end
         if (g < 0) break;
         m_rr = (g + 1) % NQ;
         n = (left[g] < BURST) ? left[g] : BURST;
         for (int k = 0; k < n; k++) begin
            rd_t e;
            logic [PL+WL-1:0] ent;
            ent    = store[g][used[g] + k];
            e.page = ent[PL+WL-1:WL];
            e.word = ent[WL-1:0];
            e.q    = g;
            e.last = (k == n - 1);
            exp_ar.push_back(g);
            exp_rd.push_back(e);
         end
         used[g] += n;
         left[g] -= n;
         exp_occ.push_back('{data: n * BPW, user: g});
      end
   endfunction

   // Plays the queue-state store and read path; checks every handshake against the model.
   task automatic responder();
      bit ar_hs = 1'b0;
      bit r_hs = 1'b0;
      bit resp_pend = 1'b0;
      int ar_q = 0;
      int resp_wait = 0;
      logic [PL+WL-1:0] resp_data = '0;
      forever begin
         @(negedge clk);
         if (!aresetn) begin
            bus.hp_arready   = 1'b0;
            bus.hp_rvalid    = 1'b0;
            bus.rd_req_ready = 1'b0;
            ar_hs = 1'b0;
            r_hs = 1'b0;
            resp_pend = 1'b0;
            continue;
         end
         if (ar_hs) begin
            n_cmp++;
            if (store[ar_q].size() == 0) begin
               n_mis++;
               $display("FAIL lookup_on_empty: queue %0d looked up with 0 words stored, required non-empty", ar_q);
               resp_data = '0;
            end else begin
               resp_data = store[ar_q].pop_front();
            end
            refresh_empty();
            resp_pend = 1'b1;
            resp_wait = slow_r ? 8 : (rand_ready ? $urandom_range(0, 3) : 0);
         end
         if (r_hs) resp_pend = 1'b0;

         bus.hp_arready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (resp_pend) begin
            if (resp_wait > 0) begin
               bus.hp_rvalid = 1'b0;
               resp_wait--;
            end else begin
               bus.hp_rvalid     = 1'b1;
               bus.hp_rdata_page = resp_data[PL+WL-1:WL];
               bus.hp_rdata_word = resp_data[WL-1:0];
            end
         end else begin
            bus.hp_rvalid     = ($urandom_range(0, 3) == 0);
            bus.hp_rdata_page = PL'($urandom);
            bus.hp_rdata_word = WL'($urandom);
         end
         bus.rd_req_ready = hold_rq ? 1'b0 : (rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1);

         ar_hs = bus.hp_arvalid && bus.hp_arready;
         ar_q  = int'(bus.hp_araddr);
         r_hs  = resp_pend && bus.hp_rvalid && bus.hp_rready;
         if (ar_hs) begin
            n_cmp++;
            if (exp_ar.size() == 0) begin
               n_mis++;
               $display("FAIL ar_addr: unexpected lookup addr=%0d, required none", ar_q);
            end else if (ar_q != exp_ar[0]) begin
               n_mis++;
               $display("FAIL ar_addr: got %0d, required %0d", ar_q, exp_ar[0]);
               void'(exp_ar.pop_front());
            end else begin
               void'(exp_ar.pop_front());
            end
         end
         if (bus.rd_req_valid && bus.rd_req_ready) begin
            n_cmp++;
            if (exp_rd.size() == 0) begin
               n_mis++;
               $display("FAIL rd_req: unexpected q=%0d page=%0d word=%0d, required none",
                        bus.rd_req_queue, bus.rd_req_page, bus.rd_req_word);
            end else begin
               rd_t e = exp_rd.pop_front();
               if (bus.rd_req_page !== e.page || bus.rd_req_word !== e.word ||
                   bus.rd_req_queue !== QL'(e.q) || bus.rd_req_last !== e.last) begin
                  n_mis++;
                  $display("FAIL rd_req: got q=%0d page=%0d word=%0d last=%0b, required q=%0d page=%0d word=%0d last=%0b",
                           bus.rd_req_queue, bus.rd_req_page, bus.rd_req_word, bus.rd_req_last,
                           e.q, e.page, e.word, e.last);
               end
            end
         end
         if (bus.deq_occ_tvalid) begin
            n_cmp++;
            obs_grants.push_back(int'(bus.deq_occ_tuser));
            obs_occ.push_back(int'(bus.deq_occ_tdata));
            if (exp_occ.size() == 0) begin
               n_mis++;
               $display("FAIL occ: unexpected tdata=%0d tuser=%0d, required none", bus.deq_occ_tdata, bus.deq_occ_tuser);
            end else begin
               occ_t e = exp_occ.pop_front();
               if (bus.deq_occ_tdata !== OCC_W'(e.data) || bus.deq_occ_tuser !== QL'(e.user)) begin
                  n_mis++;
                  $display("FAIL occ: got tdata=%0d tuser=%0d, required tdata=%0d tuser=%0d",
                           bus.deq_occ_tdata, bus.deq_occ_tuser, e.data, e.user);
               end
            end
         end
      end
   endtask

   task automatic run_until_drained(input string tag, input int budget);
      int cyc = 0;
      while ((exp_ar.size() + exp_rd.size() + exp_occ.size()) != 0 && cyc < budget) begin
         @(posedge clk);
         cyc++;
      end
      n_cmp++;
      if ((exp_ar.size() + exp_rd.size() + exp_occ.size()) != 0) begin
         n_mis++;
         $display("FAIL %s_drain: %0d events outstanding after %0d cycles, required 0",
                  tag, exp_ar.size() + exp_rd.size() + exp_occ.size(), cyc);
      end
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_mis++;
         $display("FAIL %s_idle: busy=%0b, required 0", tag, busy);
      end
   endtask

   task automatic check_list(input string tag, input int got[$], input int want[$]);
      bit bad = (got.size() != want.size());
      foreach (want[i]) if (!bad && got[i] != want[i]) bad = 1'b1;
      n_cmp++;
      if (bad) begin
         n_mis++;
         $display("FAIL %s: got %s, required %s", tag, q2str(got), q2str(want));
      end
   endtask

   function automatic logic [63:0] outs_vec();
      return 64'({bus.hp_arvalid, bus.hp_araddr, bus.hp_rready, bus.rd_req_valid, bus.rd_req_page,
                  bus.rd_req_word, bus.rd_req_queue, bus.rd_req_last, bus.deq_occ_tvalid,
                  bus.deq_occ_tdata, bus.deq_occ_tuser, busy});
   endfunction

   task automatic do_reset();
      aresetn = 1'b0;
      m_rr = 0;
      clear_expect();
      repeat (3) @(posedge clk);
      @(negedge clk);
      aresetn = 1'b1;
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (outs_vec() !== 64'd0) begin
         n_mis++;
         $display("FAIL reset_outputs: got %h, required 0", outs_vec());
      end
      @(negedge clk);
      aresetn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || bus.hp_arvalid !== 1'b0) begin
         n_mis++;
         $display("FAIL reset_idle_empty: busy=%0b arvalid=%0b, required 0/0", busy, bus.hp_arvalid);
      end
   endtask

   task automatic test_single_burst();
      int want_g[$] = '{5};
      int want_o[$] = '{256};
      @(posedge clk); #1;
      obs_grants.delete(); obs_occ.delete();
      load_queue(5, 4);
      build_expected();
      run_until_drained("single", 500);
      check_list("single_grants", obs_grants, want_g);
      check_list("single_occ", obs_occ, want_o);
   endtask

   task automatic test_long_queue();
      int want_g[$] = '{2, 2};
      int want_o[$] = '{2048, 512};
      @(posedge clk); #1;
      obs_grants.delete(); obs_occ.delete();
      load_queue(2, 40);
      build_expected();
      run_until_drained("long", 2000);
      check_list("long_grants", obs_grants, want_g);
      check_list("long_occ", obs_occ, want_o);
   endtask

   task automatic test_rr_wrap();
      int want_g[$] = '{31, 0, 9};
      do_reset();
      @(posedge clk); #1;
      load_queue(9, 1);
      build_expected();
      run_until_drained("rr_setup", 200);
      obs_grants.delete(); obs_occ.delete();
      load_queue(0, 2);
      load_queue(9, 1);
      load_queue(31, 3);
      build_expected();
      run_until_drained("rr_wrap", 1000);
      check_list("rr_wrap_order", obs_grants, want_g);
   endtask

   task automatic test_port_gate();
      bit bad = 1'b0;
      bit seen = 1'b0;
      @(posedge clk); #1;
      egr_port_ready = 4'b1110;
      load_queue(3, 2);
      repeat (8) begin
         @(posedge clk); #1;
         if (bus.hp_arvalid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      n_cmp++;
      if (bad) begin
         n_mis++;
         $display("FAIL gate_blocked: lookup or busy seen while port 0 not ready, required none");
      end
      @(negedge clk);
      egr_port_ready = 4'b1111;
      build_expected();
      repeat (2) begin
         @(posedge clk); #1;
         if (bus.hp_arvalid === 1'b1) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
         n_mis++;
         $display("FAIL gate_release: arvalid=0 within 2 cycles of port ready, required 1");
      end
      run_until_drained("gate", 500);
   endtask

   task automatic test_backpressure();
      int cyc = 0;
      logic [PL+WL+QL:0] cap;
      @(posedge clk); #1;
      hold_rq = 1'b1;
      load_queue(12, 3);
      build_expected();
      while (bus.rd_req_valid !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      n_cmp++;
      if (bus.rd_req_valid !== 1'b1) begin
         n_mis++;
         $display("FAIL bp_valid: rd_req_valid never rose in 40 cycles, required 1");
      end
      cap = {bus.rd_req_page, bus.rd_req_word, bus.rd_req_queue, bus.rd_req_last};
      repeat (5) begin
         @(posedge clk); #1;
         n_cmp++;
         if ({bus.rd_req_page, bus.rd_req_word, bus.rd_req_queue, bus.rd_req_last} !== cap ||
             bus.rd_req_valid !== 1'b1 || bus.hp_arvalid !== 1'b0) begin
            n_mis++;
            $display("FAIL bp_hold: payload=%h valid=%0b arvalid=%0b, required payload=%h valid=1 arvalid=0",
                     {bus.rd_req_page, bus.rd_req_word, bus.rd_req_queue, bus.rd_req_last},
                     bus.rd_req_valid, bus.hp_arvalid, cap);
         end
      end
      hold_rq = 1'b0;
      run_until_drained("bp", 500);
   endtask

   task automatic test_reset_in_r();
      int cyc = 0;
      int want_g[$] = '{3, 25};
      int want_o[$] = '{192, 256};
      do_reset();
      @(posedge clk); #1;
      load_queue(20, 1);
      build_expected();
      run_until_drained("rst_setup", 200);
      load_queue(25, 5);
      load_queue(3, 3);
      slow_r = 1'b1;
      build_expected();
      while (bus.hp_rready !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      @(negedge clk); #1;
      aresetn = 1'b0;
      #1;
      n_cmp++;
      if (outs_vec() !== 64'd0) begin
         n_mis++;
         $display("FAIL reset_in_r: outputs %h, required 0 at once", outs_vec());
      end
      clear_expect();
      slow_r = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         n_cmp++;
         if (bus.deq_occ_tvalid !== 1'b0 || busy !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_hold: occ_tvalid=%0b busy=%0b, required 0/0", bus.deq_occ_tvalid, busy);
         end
      end
      @(negedge clk);
      aresetn = 1'b1;
      m_rr = 0;
      build_expected();
      run_until_drained("rst_regrant", 1000);
      check_list("rst_regrant_order", obs_grants, want_g);
      check_list("rst_regrant_occ", obs_occ, want_o);
   endtask

   task automatic test_random();
      rand_ready = 1'b1;
      for (int it = 0; it < 4; it++) begin
         @(posedge clk); #1;
         clear_store();
         for (int q = 0; q < NQ; q++) if ($urandom_range(0, 2) == 0) load_queue(q, $urandom_range(1, 40));
         egr_port_ready = NEP'($urandom_range(1, 15));
         build_expected();
         run_until_drained($sformatf("rand%0d", it), 20000);
         clear_store();
      end
      rand_ready = 1'b0;
      egr_port_ready = '1;
   endtask

   initial begin
      aresetn            = 1'b0;
      egr_port_ready     = '1;
      bus.hp_arready     = 1'b0;
      bus.hp_rvalid      = 1'b0;
      bus.hp_rdata_page  = '0;
      bus.hp_rdata_word  = '0;
      bus.rd_req_ready   = 1'b0;
      clear_store();
      fork
         responder();
      join_none
      test_reset();
      test_single_burst();
      test_long_queue();
      test_rr_wrap();
      test_port_gate();
      test_backpressure();
      test_reset_in_r();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
